// File: rtl/imuldiv_int_div_iterative_param_pkg.sv
// ----------------------------------------------------------------------------
// imuldiv_int_div_iterative_param_pkg
//   Shared encodings for the iterative divider: divide-request function codes
//   and the 2-bit controller state encodings.
//   No ports (package).
// ----------------------------------------------------------------------------
package imuldiv_int_div_iterative_param_pkg;

  // Divide-request function field
  localparam logic IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED = 1'b0;
  localparam logic IMULDIV_DIVREQ_MSG_FUNC_SIGNED   = 1'b1;

  // Controller states (plain constants so legacy code can share them)
  localparam logic [1:0] IMULDIV_DIV_STATE_IDLE = 2'd0;
  localparam logic [1:0] IMULDIV_DIV_STATE_CALC = 2'd1;
  localparam logic [1:0] IMULDIV_DIV_STATE_DONE = 2'd2;

endpackage

// File: rtl/imuldiv_int_div_iterative_param_ctrl.sv
// ----------------------------------------------------------------------------
// imuldiv_int_div_iterative_param_ctrl
//   Control FSM of the iterative divider: IDLE -> CALC -> DONE -> IDLE.
//   Owns the iteration counter and the request/response handshakes, and
//   tells the datapath when to load operands and when to iterate.
// Ports
//   clk, reset    clock, synchronous active-high reset
//   i_req_val     request valid            o_req_rdy   request ready
//   i_resp_rdy    response ready           o_resp_val  response valid
//   i_skip        operands need no iterations (early-exit builds only)
//   o_load        latch operands this cycle
//   o_step        perform one quotient-bit iteration this cycle
// ----------------------------------------------------------------------------
module imuldiv_int_div_iterative_param_ctrl
  import imuldiv_int_div_iterative_param_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_val,
  output logic o_req_rdy,
  input  logic i_resp_rdy,
  output logic o_resp_val,
  input  logic i_skip,
  output logic o_load,
  output logic o_step
);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;

  // Ready is masked by reset so nothing is accepted in the reset cycle.
  assign o_req_rdy  = (r_state == IMULDIV_DIV_STATE_IDLE) && !reset;
  assign o_resp_val = (r_state == IMULDIV_DIV_STATE_DONE);
  assign o_load     = i_req_val && o_req_rdy;
  assign o_step     = (r_state == IMULDIV_DIV_STATE_CALC) && (r_count != '0);

  // CALC runs W iteration cycles while the counter is non-zero, then one
  // more cycle with the counter at zero to hand over to DONE. That gives the
  // W+1 cycle accept-to-valid latency. A skipped operation enters CALC with
  // the counter already at zero, so it becomes valid one cycle after accept.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IMULDIV_DIV_STATE_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IMULDIV_DIV_STATE_IDLE: begin
          if (o_load) begin
            r_state <= IMULDIV_DIV_STATE_CALC;
            r_count <= i_skip ? '0 : CW'(W);
          end
        end
        IMULDIV_DIV_STATE_CALC: begin
          if (r_count != '0) r_count <= r_count - 1'b1;
          else               r_state <= IMULDIV_DIV_STATE_DONE;
        end
        IMULDIV_DIV_STATE_DONE: begin
          if (i_resp_rdy) r_state <= IMULDIV_DIV_STATE_IDLE;
        end
        default: r_state <= IMULDIV_DIV_STATE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imuldiv_int_div_iterative_param.sv
// ----------------------------------------------------------------------------
// imuldiv_int_div_iterative_param
//   Parametrised multi-cycle restoring divider (one quotient bit per cycle)
//   for the PARC muldiv unit. Signed operations divide magnitudes and fix up
//   the signs on the output; divide-by-zero returns quotient all ones and
//   remainder = dividend; signed MIN / -1 returns MIN with remainder 0.
// Optional feature
//   IMULDIV_DIV_EARLY_EXIT_EN  when defined, b==0 or |a|<|b| skips the
//                              iterations and responds one cycle after accept.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   divreq_msg_fn                   0 unsigned, 1 signed
//   divreq_msg_a / divreq_msg_b     dividend / divisor (W bits)
//   divreq_val / divreq_rdy         request handshake
//   divresp_msg_result              {remainder, quotient} (2W bits)
//   divresp_val / divresp_rdy       response handshake
// ----------------------------------------------------------------------------
module imuldiv_int_div_iterative_param
  import imuldiv_int_div_iterative_param_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           divreq_msg_fn,
  input  logic [W-1:0]   divreq_msg_a,
  input  logic [W-1:0]   divreq_msg_b,
  input  logic           divreq_val,
  output logic           divreq_rdy,
  output logic [2*W-1:0] divresp_msg_result,
  output logic           divresp_val,
  input  logic           divresp_rdy
);

  logic [W:0]   r_rem;      // partial remainder accumulator
  logic [W-1:0] r_quo;      // dividend shifting out / quotient shifting in
  logic [W-1:0] r_b_mag;    // divisor magnitude
  logic         r_sign_q;
  logic         r_sign_r;
  logic         r_b_zero;

  logic         w_load;
  logic         w_step;
  logic         w_skip;
  logic         w_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic [W+1:0] w_diff;
  logic [W-1:0] w_quo_out;
  logic [W-1:0] w_rem_out;

  imuldiv_int_div_iterative_param_ctrl #(.W(W), .CW(CW)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_req_val  (divreq_val),
    .o_req_rdy  (divreq_rdy),
    .i_resp_rdy (divresp_rdy),
    .o_resp_val (divresp_val),
    .i_skip     (w_skip),
    .o_load     (w_load),
    .o_step     (w_step)
  );

  // Magnitudes are W-bit unsigned, so |MIN| = 2^(W-1) is representable.
  assign w_signed = (divreq_msg_fn == IMULDIV_DIVREQ_MSG_FUNC_SIGNED);
  assign w_a_neg  = w_signed && divreq_msg_a[W-1];
  assign w_b_neg  = w_signed && divreq_msg_b[W-1];
  assign w_a_mag  = w_a_neg ? -divreq_msg_a : divreq_msg_a;
  assign w_b_mag  = w_b_neg ? -divreq_msg_b : divreq_msg_b;

`ifdef IMULDIV_DIV_EARLY_EXIT_EN
  assign w_skip = (w_b_mag == '0) || (w_a_mag < w_b_mag);
`else
  assign w_skip = 1'b0;
`endif

  // Trial subtraction one bit wider than the shifted remainder so its MSB
  // is a clean "went negative" flag.
  assign w_diff = {r_rem, r_quo[W-1]} - {2'b00, r_b_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_b_mag  <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_load) begin
      // A skipped op already has its answer: quotient 0, remainder |a|.
      r_rem    <= w_skip ? {1'b0, w_a_mag} : '0;
      r_quo    <= w_skip ? '0 : w_a_mag;
      r_b_mag  <= w_b_mag;
      r_sign_q <= w_a_neg ^ w_b_neg;
      r_sign_r <= w_a_neg;
      r_b_zero <= (divreq_msg_b == '0);
    end else if (w_step) begin
      if (!w_diff[W+1]) begin
        r_rem <= w_diff[W:0];
        r_quo <= {r_quo[W-2:0], 1'b1};
      end else begin
        r_rem <= {r_rem[W-1:0], r_quo[W-1]};
        r_quo <= {r_quo[W-2:0], 1'b0};
      end
    end
  end

  // Divide-by-zero forces the quotient to all ones; the remainder needs no
  // override since negating |a| under sign_r reproduces the dividend bits.
  assign w_quo_out = r_b_zero ? '1 : (r_sign_q ? -r_quo : r_quo);
  assign w_rem_out = r_sign_r ? -r_rem[W-1:0] : r_rem[W-1:0];
  assign divresp_msg_result = {w_rem_out, w_quo_out};

endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// ----------------------------------------------------------------------------
// tb_imuldiv_int_div_iterative_param
//   Self-checking bench for the iterative divider: a W=32 and a W=8 instance,
//   a reference model built on the language's / and % operators, and a
//   scoreboard queue of expected results.
// ----------------------------------------------------------------------------
module tb_imuldiv_int_div_iterative_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        fn32, val32, rdy32, rval32, rrdy32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  logic        fn8, val8, rdy8, rval8, rrdy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  imuldiv_int_div_iterative_param #(.W(32)) dut32 (
    .clk(clk), .reset(reset),
    .divreq_msg_fn(fn32), .divreq_msg_a(a32), .divreq_msg_b(b32),
    .divreq_val(val32), .divreq_rdy(rdy32),
    .divresp_msg_result(res32), .divresp_val(rval32), .divresp_rdy(rrdy32)
  );

  imuldiv_int_div_iterative_param #(.W(8)) dut8 (
    .clk(clk), .reset(reset),
    .divreq_msg_fn(fn8), .divreq_msg_a(a8), .divreq_msg_b(b8),
    .divreq_val(val8), .divreq_rdy(rdy8),
    .divresp_msg_result(res8), .divresp_val(rval8), .divresp_rdy(rrdy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {remainder, quotient} packed as (r << w) | q.
  function automatic logic [63:0] ref_div(input int w, input logic fn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, uq, ur;
    longint      sa, sb_v, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (ub == 64'd0) begin
      uq = mask;
      ur = ua;
    end else if (!fn) begin
      uq = ua / ub;
      ur = ua % ub;
    end else begin
      sa   = $signed(ua << (64 - w)) >>> (64 - w);
      sb_v = $signed(ub << (64 - w)) >>> (64 - w);
      q  = sa / sb_v;
      r  = sa % sb_v;
      uq = 64'(q) & mask;
      ur = 64'(r) & mask;
    end
    return (ur << w) | uq;
  endfunction

  function automatic bit exp_skip(input int w, input logic fn,
                                  input logic [31:0] a, input logic [31:0] b);
`ifdef IMULDIV_DIV_EARLY_EXIT_EN
    logic [63:0] mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    if (fn && ua[w-1]) ua = (~ua + 64'd1) & mask;
    if (fn && ub[w-1]) ub = (~ub + 64'd1) & mask;
    return (ub == 64'd0) || (ua < ub);
`else
    return (w < 0) && fn && (a == b);  // never true: no early exit in this build
`endif
  endfunction

  function automatic logic got_rdy(input bit n);
    return n ? rdy8 : rdy32;
  endfunction

  function automatic logic got_val(input bit n);
    return n ? rval8 : rval32;
  endfunction

  function automatic logic [63:0] got_res(input bit n);
    return n ? {48'd0, res8} : res32;
  endfunction

  task automatic drive_req(input bit n, input logic v, input logic fn,
                           input logic [31:0] a, input logic [31:0] b);
    if (n) begin
      val8 = v; fn8 = fn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      val32 = v; fn32 = fn; a32 = a; b32 = b;
    end
  endtask

  task automatic set_resp_rdy(input bit n, input logic v);
    if (n) rrdy8 = v;
    else   rrdy32 = v;
  endtask

  // One complete operation; `hold` cycles of response backpressure.
  task automatic run_op(input bit n, input logic fn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp, exp_q;
    int          w, lat, exp_lat, guard;
    w       = n ? 8 : 32;
    exp     = ref_div(w, fn, a, b);
    exp_lat = exp_skip(w, fn, a, b) ? 1 : w + 1;
    guard   = 0;
    while (!got_rdy(n) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_rdy_wait", 64'(got_rdy(n)), 64'd1);
    drive_req(n, 1'b1, fn, a, b);
    sb.push_back(exp);
    @(posedge clk); #1;
    drive_req(n, 1'b0, 1'b0, 32'd0, 32'd0);
    lat = 0;
    while (!got_val(n) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check("hold_val", 64'(got_val(n)), 64'd1);
      check("hold_res", got_res(n), exp);
      check("hold_req_rdy", 64'(got_rdy(n)), 64'd0);
      drive_req(n, 1'b1, ~fn, ~a, b + 32'd1);  // must be ignored
      @(posedge clk); #1;
    end
    drive_req(n, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_q = sb.pop_front();
    check("result", got_res(n), exp_q);
    set_resp_rdy(n, 1'b1);
    @(posedge clk); #1;
    set_resp_rdy(n, 1'b0);
    check("back_idle", 64'(got_rdy(n)), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rfn;
    logic [31:0] ra, rb;
    reset = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    rrdy32 = 1'b0;
    rrdy8  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", 64'(rdy32), 64'd0);
    check("rst_resp_val", 64'(rval32), 64'd0);
    check("rst_result", res32, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_idle", 64'(rdy32), 64'd1);

    // W=32 directed cases
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    check("sb_100_7", ref_div(32, 1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_op(1'b0, 1'b1, -32'sd7, 32'd2, 0);
    run_op(1'b0, 1'b1, 32'd7, -32'sd2, 0);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 0);
    run_op(1'b0, 1'b1, -32'sd5, 32'd0, 0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 1'b1, 32'd0, 32'd9, 0);
    run_op(1'b0, 1'b0, 32'd3, 32'd7, 0);

    // Backpressure, then a back-to-back operation
    run_op(1'b0, 1'b0, 32'd1000, 32'd33, 10);
    run_op(1'b0, 1'b1, -32'sd1000, 32'd33, 0);

    // Reset in the middle of CALC aborts the operation
    drive_req(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_resp_val", 64'(rval32), 64'd0);
    check("abort_req_rdy", 64'(rdy32), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 64'(rdy32), 64'd1);
    check("abort_no_val", 64'(rval32), 64'd0);
    run_op(1'b0, 1'b0, 32'd9, 32'd3, 0);

    // W=8 directed and random
    run_op(1'b1, 1'b0, 32'd3, 32'd7, 0);
    run_op(1'b1, 1'b1, 32'h80, 32'hFF, 0);
    run_op(1'b1, 1'b1, 32'hF9, 32'd0, 0);
    for (int i = 0; i < 40; i++) begin
      rfn = 1'($urandom_range(0, 1));
      ra  = 32'($urandom_range(0, 255));
      rb  = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      run_op(1'b1, rfn, ra, rb, (i % 10 == 3) ? 2 : 0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
